// File: rtl/dac_feeder_pkg.sv
// rtl/dac_feeder_pkg.sv - shared widths, pair packing and helpers for the DAC sample feeder
package dac_feeder_pkg;

    localparam int DATA_W     = 14;
    localparam int DEPTH_LOG2 = 3;
    localparam int RATE_W     = 16;
    localparam int UFL_W      = 16;

    localparam int A_LSB  = 0;
    localparam int B_LSB  = DATA_W;
    localparam int PAIR_W = 2 * DATA_W;

    typedef logic [DATA_W-1:0] sample_t;

    typedef struct packed {
        sample_t b;
        sample_t a;
    } pair_t;

    function automatic pair_t unpack_pair(input logic [PAIR_W-1:0] word);
        pair_t p;
        p.a = word[A_LSB +: DATA_W];
        p.b = word[B_LSB +: DATA_W];
        return p;
    endfunction

endpackage

// File: rtl/dac_sample_feeder_if.sv
// rtl/dac_sample_feeder_if.sv - valid/ready sample-pair stream into the feeder
interface dac_sample_feeder_if;
    import dac_feeder_pkg::*;

    logic [PAIR_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;

    modport master (output s_data, output s_valid, input  s_ready);
    modport slave  (input  s_data, input  s_valid, output s_ready);

endinterface

// File: rtl/dac_feeder_fifo.sv
// rtl/dac_feeder_fifo.sv - synchronous show-ahead FIFO of sample pairs, register storage
module dac_feeder_fifo
    import dac_feeder_pkg::*;
#(
    parameter int WIDTH = PAIR_W,
    parameter int AW    = DEPTH_LOG2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem [0:(1<<AW)-1];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // The extra pointer MSB distinguishes full from empty when the low bits match.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr[AW-1:0]] <= data;
    end

    assign head  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level = wr_ptr - rd_ptr;

endmodule

// File: rtl/dac_sample_feeder.sv
// rtl/dac_sample_feeder.sv - paces buffered A/B sample pairs out to the DAC stage at a programmable rate
module dac_sample_feeder
    import dac_feeder_pkg::*;
(
    input  logic                  dac_clk_i,
    input  logic                  dac_rst_ni,
    dac_sample_feeder_if.slave    s,
    input  logic                  run_i,
    input  logic                  clear_i,
    input  logic [RATE_W-1:0]     rate_i,
    output logic [DATA_W-1:0]     dac_dat_a_o,
    output logic [DATA_W-1:0]     dac_dat_b_o,
    output logic                  dac_dat_a_en_o,
    output logic                  dac_dat_b_en_o,
    output logic                  dac_dat_a_rst_o,
    output logic                  dac_dat_b_rst_o,
    output logic [DEPTH_LOG2:0]   level_o,
    output logic                  underflow_o,
    output logic [UFL_W-1:0]      ufl_cnt_o
);

    logic              ready_en_q;
    logic              chan_rst_q;
    logic [RATE_W-1:0] cnt_q;
    logic [DATA_W-1:0] dat_a_q;
    logic [DATA_W-1:0] dat_b_q;
    logic              en_q;
    logic              ufl_q;
    logic [UFL_W-1:0]  ufl_cnt_q;

    logic              push;
    logic              pop;
    logic              tick;
    logic              ufl_evt;
    logic              empty;
    logic              full;
    logic [PAIR_W-1:0] fifo_head;
    pair_t             head_pair;

    dac_feeder_fifo #(
        .WIDTH (PAIR_W),
        .AW    (DEPTH_LOG2)
    ) u_fifo (
        .clk   (dac_clk_i),
        .rst_n (dac_rst_ni),
        .push  (push),
        .pop   (pop),
        .flush (clear_i),
        .data  (s.s_data),
        .head  (fifo_head),
        .empty (empty),
        .full  (full),
        .level (level_o)
    );

    assign s.s_ready = ready_en_q & ~full & ~clear_i;
    assign push      = s.s_valid & s.s_ready;

    // >= rather than == so a rate lowered below the running count ticks at once.
    assign tick    = run_i & (cnt_q >= rate_i);
    assign pop     = tick & ~empty & ~clear_i;
    assign ufl_evt = tick & empty & ~clear_i;

    assign head_pair = unpack_pair(fifo_head);

    always_ff @(posedge dac_clk_i or negedge dac_rst_ni) begin
        if (!dac_rst_ni) begin
            ready_en_q <= 1'b0;
            chan_rst_q <= 1'b1;
            cnt_q      <= '0;
            dat_a_q    <= '0;
            dat_b_q    <= '0;
            en_q       <= 1'b0;
            ufl_q      <= 1'b0;
            ufl_cnt_q  <= '0;
        end else begin
            ready_en_q <= 1'b1;
            chan_rst_q <= clear_i;
            en_q       <= pop;

            if (clear_i || !run_i || tick) cnt_q <= '0;
            else                           cnt_q <= cnt_q + 1'b1;

            if (pop) begin
                dat_a_q <= head_pair.a;
                dat_b_q <= head_pair.b;
            end

            if (clear_i) begin
                ufl_q     <= 1'b0;
                ufl_cnt_q <= '0;
            end else if (ufl_evt) begin
                ufl_q <= 1'b1;
                if (ufl_cnt_q != '1) ufl_cnt_q <= ufl_cnt_q + 1'b1;
            end
        end
    end

    assign dac_dat_a_o     = dat_a_q;
    assign dac_dat_b_o     = dat_b_q;
    assign dac_dat_a_en_o  = en_q;
    assign dac_dat_b_en_o  = en_q;
    assign dac_dat_a_rst_o = clear_i | chan_rst_q;
    assign dac_dat_b_rst_o = clear_i | chan_rst_q;
    assign underflow_o     = ufl_q;
    assign ufl_cnt_o       = ufl_cnt_q;

endmodule

// File: tb/tb_dac_sample_feeder.sv
// tb/tb_dac_sample_feeder.sv - directed bench for dac_sample_feeder against a queue-based model
module tb_dac_sample_feeder;
    import dac_feeder_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        clear;
    logic [15:0] rate;
    logic [13:0] dat_a, dat_b;
    logic        en_a, en_b, rst_a, rst_b;
    logic [3:0]  level;
    logic        underflow;
    logic [15:0] ufl_cnt;

    int n_checks = 0;
    int n_err    = 0;
    int strobes  = 0;
    int rst_hi   = 0;

    dac_sample_feeder_if sif();

    dac_sample_feeder dut (
        .dac_clk_i       (clk),
        .dac_rst_ni      (rst_n),
        .s               (sif),
        .run_i           (run),
        .clear_i         (clear),
        .rate_i          (rate),
        .dac_dat_a_o     (dat_a),
        .dac_dat_b_o     (dat_b),
        .dac_dat_a_en_o  (en_a),
        .dac_dat_b_en_o  (en_b),
        .dac_dat_a_rst_o (rst_a),
        .dac_dat_b_rst_o (rst_b),
        .level_o         (level),
        .underflow_o     (underflow),
        .ufl_cnt_o       (ufl_cnt)
    );

    always #5 clk = ~clk;

    // Model: what the feeder must hold after each clock edge.
    logic [27:0] mq[$];
    int          m_cnt;
    logic [13:0] m_a, m_b;
    bit          m_en, m_ufl, m_clear_q;
    int          m_ufl_cnt;
    int          m_since;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_cnt = 0; m_a = '0; m_b = '0; m_en = 0; m_ufl = 0;
            m_ufl_cnt = 0; m_clear_q = 0; m_since = 0;
        end else begin
            bit rdy, tk;
            logic [27:0] pr;
            rdy = (m_since >= 1) && (mq.size() < 8) && !clear;
            if (clear) begin
                mq.delete();
                m_cnt = 0; m_en = 0; m_ufl = 0; m_ufl_cnt = 0;
            end else begin
                tk    = run && (m_cnt >= int'(rate));
                m_cnt = (run && !tk) ? m_cnt + 1 : 0;
                m_en  = tk && (mq.size() > 0);
                if (m_en) begin
                    pr  = mq.pop_front();
                    m_a = pr[13:0];
                    m_b = pr[27:14];
                end else if (tk) begin
                    m_ufl = 1;
                    if (m_ufl_cnt < 65535) m_ufl_cnt++;
                end
                if (sif.s_valid && rdy) mq.push_back(sif.s_data);
            end
            m_clear_q = clear;
            if (m_since < 2) m_since++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic exp_rst, exp_rdy;
        exp_rst = clear || m_clear_q || (m_since == 0);
        exp_rdy = (m_since >= 1) && (mq.size() < 8) && !clear;
        chk("rst_a", rst_a, exp_rst);
        chk("rst_b", rst_b, exp_rst);
        chk("ready", sif.s_ready, exp_rdy);
        chk("level", level, mq.size());
        chk("en_a", en_a, m_en);
        chk("en_b", en_b, m_en);
        chk("dat_a", dat_a, m_a);
        chk("dat_b", dat_b, m_b);
        chk("underflow", underflow, m_ufl);
        chk("ufl_cnt", ufl_cnt, m_ufl_cnt);
        if (en_a === 1'b1) strobes++;
        if (rst_a === 1'b1) rst_hi++;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            compare_all();
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [27:0] mk(input int b, input int a);
        logic [13:0] bb, aa;
        bb = 14'(b);
        aa = 14'(a);
        return {bb, aa};
    endfunction

    initial begin
        int s0, r0, last_s;
        rst_n = 1'b0; run = 1'b0; clear = 1'b0; rate = '0;
        sif.s_valid = 1'b0; sif.s_data = '0;
        step(3);

        // Reset release
        rst_n = 1'b1;
        chk("lit_rst_cycle1", rst_a, 1);
        chk("lit_ready_cycle1", sif.s_ready, 0);
        step(1);
        chk("lit_rst_cycle2", rst_a, 0);
        chk("lit_ready_cycle2", sif.s_ready, 1);
        step(2);

        // Two pairs, rate 0: strobes land two cycles after the write
        sif.s_valid = 1'b1; sif.s_data = mk('h3FFF, 'h0001); run = 1'b1; rate = 16'd0;
        step(1);
        sif.s_data = mk('h2000, 'h0002);
        chk("lit_lat_en0", en_a, 0);
        step(1);
        sif.s_valid = 1'b0;
        chk("lit_lat_en1", en_a, 1);
        chk("lit_lat_a1", dat_a, 'h0001);
        chk("lit_lat_b1", dat_b, 'h3FFF);
        step(1);
        chk("lit_lat_a2", dat_a, 'h0002);
        chk("lit_lat_b2", dat_b, 'h2000);
        chk("lit_lat_level", level, 0);
        step(1);
        chk("lit_hold_a", dat_a, 'h0002);
        run = 1'b0; clear = 1'b1;
        step(1);
        clear = 1'b0;
        step(2);

        // Preload beyond depth, then drain at rate 3
        rate = 16'd3; sif.s_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            sif.s_data = mk(i * 37 + 1, 16383 - i);
            step(1);
        end
        sif.s_valid = 1'b0;
        chk("lit_full_level", level, 8);
        chk("lit_full_ready", sif.s_ready, 0);
        s0 = strobes; last_s = -1; run = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            step(1);
            if (en_a === 1'b1) begin
                if (last_s >= 0) chk("lit_strobe_gap", i - last_s, 4);
                last_s = i;
            end
        end
        chk("lit_strobe_total", strobes - s0, 8);
        chk("lit_drain_ufl", ufl_cnt, 2);

        // Rate lowered below a running count ticks on the next edge
        run = 1'b0; clear = 1'b1;
        step(1);
        clear = 1'b0; run = 1'b1; rate = 16'd6;
        step(4);
        rate = 16'd1;
        step(1);
        chk("lit_rate_drop_tick", ufl_cnt, 1);

        // Empty FIFO, rate 1, 10 cycles -> 5 underflows
        run = 1'b0; clear = 1'b1;
        step(1);
        clear = 1'b0; run = 1'b1; rate = 16'd1; s0 = strobes;
        step(10);
        run = 1'b0;
        chk("lit_ufl5_cnt", ufl_cnt, 5);
        chk("lit_ufl5_flag", underflow, 1);
        chk("lit_ufl5_nostrobe", strobes - s0, 0);
        step(1);

        // Underflow count saturation
        clear = 1'b1;
        step(1);
        clear = 1'b0; run = 1'b1; rate = 16'd0;
        step(65534);
        chk("lit_sat_fffe", ufl_cnt, 'hFFFE);
        step(3);
        chk("lit_sat_ffff", ufl_cnt, 'hFFFF);
        run = 1'b0;
        step(1);

        // Flush with level 5 while ticking and writing
        sif.s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sif.s_data = mk(100 + i, 200 + i);
            step(1);
        end
        chk("lit_flush_pre_level", level, 5);
        s0 = strobes; r0 = rst_hi;
        sif.s_data = mk('h0ABC, 'h0123); clear = 1'b1; run = 1'b1; rate = 16'd0;
        step(2);
        clear = 1'b0; run = 1'b0; sif.s_valid = 1'b0;
        step(3);
        chk("lit_flush_rst_cycles", rst_hi - r0, 3);
        chk("lit_flush_level", level, 0);
        chk("lit_flush_ufl_cnt", ufl_cnt, 0);
        chk("lit_flush_ufl_flag", underflow, 0);
        chk("lit_flush_nostrobe", strobes - s0, 0);
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
